// File: rtl/lieat_exu_mul_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : lieat_exu_mul_ctrl
//  Purpose  : Issue-side controller for the EXU multiplier (RV32M MUL,
//             MULH, MULHSU, MULHU). Decodes operand signedness, runs the
//             multiplier request/response handshakes, selects the high or
//             low product word for writeback, and keeps a one-entry product
//             cache so a MULH*/MUL pair on identical operands costs a
//             single multiplier pass.
//  Ports    :
//    clock, reset (sync, active-low), flush
//    op_i_*   : op request (valid/ready, func, rs1, rs2, rd)
//    mul_i_*  : multiplier request (valid/ready, signedness, operands)
//    mul_o_*  : multiplier response (valid/ready, resh, resl)
//    wb_o_*   : writeback (valid/ready, rd, data)
//  Revision : 1.0 - initial release
// ============================================================================
module lieat_exu_mul_ctrl #(
    parameter int XLEN     = 32,
    parameter int RD_W     = 5,
    parameter int CACHE_EN = 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            flush,
    input  logic            op_i_valid,
    output logic            op_i_ready,
    input  logic [1:0]      op_i_func,
    input  logic [XLEN-1:0] op_i_rs1,
    input  logic [XLEN-1:0] op_i_rs2,
    input  logic [RD_W-1:0] op_i_rd,
    output logic            mul_i_valid,
    input  logic            mul_i_ready,
    output logic            mul_i_signed1,
    output logic            mul_i_signed2,
    output logic [XLEN-1:0] mul_i_multiplicand,
    output logic [XLEN-1:0] mul_i_multiplier,
    input  logic            mul_o_valid,
    output logic            mul_o_ready,
    input  logic [XLEN-1:0] mul_o_resh,
    input  logic [XLEN-1:0] mul_o_resl,
    output logic            wb_o_valid,
    input  logic            wb_o_ready,
    output logic [RD_W-1:0] wb_o_rd,
    output logic [XLEN-1:0] wb_o_data
);

    localparam logic [1:0] c_FUNC_MUL   = 2'b00;
    localparam logic [1:0] c_FUNC_MULH  = 2'b01;
    localparam logic [1:0] c_FUNC_MULHU = 2'b11;

    typedef enum logic [4:0] {
        S_IDLE  = 5'b00001,
        S_REQ   = 5'b00010,
        S_WAIT  = 5'b00100,
        S_DRAIN = 5'b01000,
        S_WB    = 5'b10000
    } state_t;

    state_t r_state;
    state_t w_next;

    // Accepted-op registers
    logic [XLEN-1:0] r_rs1;
    logic [XLEN-1:0] r_rs2;
    logic [RD_W-1:0] r_rd;
    logic [1:0]      r_func;
    logic            r_s1;
    logic            r_s2;
    logic [XLEN-1:0] r_wb_data;

    // Product cache
    logic            r_c_v;
    logic [XLEN-1:0] r_c_rs1;
    logic [XLEN-1:0] r_c_rs2;
    logic            r_c_s1;
    logic            r_c_s2;
    logic [XLEN-1:0] r_c_resh;
    logic [XLEN-1:0] r_c_resl;

    logic            w_dec_s1;
    logic            w_dec_s2;
    logic            w_accept;
    logic            w_hit;
    logic            w_sign_match;
    logic [XLEN-1:0] w_hit_data;

    assign w_dec_s1 = (op_i_func != c_FUNC_MULHU);
    assign w_dec_s2 = (op_i_func == c_FUNC_MULH);

    // MUL only returns the low word, which is identical for every
    // signedness combination, so its signs need not match the entry.
    assign w_sign_match = (op_i_func == c_FUNC_MUL) ||
                          ((w_dec_s1 == r_c_s1) && (w_dec_s2 == r_c_s2));
    assign w_hit        = (CACHE_EN != 0) && r_c_v &&
                          (op_i_rs1 == r_c_rs1) && (op_i_rs2 == r_c_rs2) &&
                          w_sign_match;
    assign w_hit_data   = (op_i_func == c_FUNC_MUL) ? r_c_resl : r_c_resh;

    // Handshake outputs decoded from state
    assign op_i_ready  = (r_state == S_IDLE) && !flush;
    assign w_accept    = op_i_valid && op_i_ready;
    assign mul_i_valid = (r_state == S_REQ) && !flush;
    assign mul_o_ready = (r_state == S_WAIT) || (r_state == S_DRAIN);
    assign wb_o_valid  = (r_state == S_WB) && !flush;

    assign mul_i_signed1      = r_s1;
    assign mul_i_signed2      = r_s2;
    assign mul_i_multiplicand = r_rs1;
    assign mul_i_multiplier   = r_rs2;
    assign wb_o_rd            = r_rd;
    assign wb_o_data          = r_wb_data;

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = w_hit ? S_WB : S_REQ;
                end
            end
            S_REQ: begin
                if (flush) begin
                    w_next = S_IDLE;
                end else if (mul_i_ready) begin
                    w_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mul_o_valid) begin
                    w_next = flush ? S_IDLE : S_WB;
                end else if (flush) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (mul_o_valid) begin
                    w_next = S_IDLE;
                end
            end
            S_WB: begin
                if (flush || wb_o_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // State register and datapath
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_rs1     <= '0;
            r_rs2     <= '0;
            r_rd      <= '0;
            r_func    <= '0;
            r_s1      <= 1'b0;
            r_s2      <= 1'b0;
            r_wb_data <= '0;
            r_c_v     <= 1'b0;
            r_c_rs1   <= '0;
            r_c_rs2   <= '0;
            r_c_s1    <= 1'b0;
            r_c_s2    <= 1'b0;
            r_c_resh  <= '0;
            r_c_resl  <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_rs1  <= op_i_rs1;
                        r_rs2  <= op_i_rs2;
                        r_rd   <= op_i_rd;
                        r_func <= op_i_func;
                        r_s1   <= w_dec_s1;
                        r_s2   <= w_dec_s2;
                        if (w_hit) begin
                            r_wb_data <= w_hit_data;
                        end
                    end
                end
                S_WAIT: begin
                    // A flushed-but-completed result still refreshes the
                    // cache; only a result arriving in DRAIN is discarded.
                    if (mul_o_valid) begin
                        r_c_v    <= 1'b1;
                        r_c_rs1  <= r_rs1;
                        r_c_rs2  <= r_rs2;
                        r_c_s1   <= r_s1;
                        r_c_s2   <= r_s2;
                        r_c_resh <= mul_o_resh;
                        r_c_resl <= mul_o_resl;
                        if (!flush) begin
                            r_wb_data <= (r_func == c_FUNC_MUL) ? mul_o_resl
                                                                : mul_o_resh;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lieat_exu_mul_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lieat_exu_mul_ctrl
//  Purpose  : Self-checking bench for lieat_exu_mul_ctrl with a behavioural
//             multiplier, a writeback scoreboard and a vector table.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lieat_exu_mul_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        op_i_valid = 1'b0;
    logic        op_i_ready;
    logic [1:0]  op_i_func = '0;
    logic [31:0] op_i_rs1 = '0;
    logic [31:0] op_i_rs2 = '0;
    logic [4:0]  op_i_rd = '0;
    logic        mul_i_valid;
    logic        mul_i_ready;
    logic        mul_i_signed1;
    logic        mul_i_signed2;
    logic [31:0] mul_i_multiplicand;
    logic [31:0] mul_i_multiplier;
    logic        mul_o_valid;
    logic        mul_o_ready;
    logic [31:0] mul_o_resh;
    logic [31:0] mul_o_resl;
    logic        wb_o_valid;
    logic        wb_o_ready = 1'b1;
    logic [4:0]  wb_o_rd;
    logic [31:0] wb_o_data;

    lieat_exu_mul_ctrl #(.XLEN(32), .RD_W(5), .CACHE_EN(1)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .op_i_valid(op_i_valid), .op_i_ready(op_i_ready),
        .op_i_func(op_i_func), .op_i_rs1(op_i_rs1), .op_i_rs2(op_i_rs2),
        .op_i_rd(op_i_rd),
        .mul_i_valid(mul_i_valid), .mul_i_ready(mul_i_ready),
        .mul_i_signed1(mul_i_signed1), .mul_i_signed2(mul_i_signed2),
        .mul_i_multiplicand(mul_i_multiplicand),
        .mul_i_multiplier(mul_i_multiplier),
        .mul_o_valid(mul_o_valid), .mul_o_ready(mul_o_ready),
        .mul_o_resh(mul_o_resh), .mul_o_resl(mul_o_resl),
        .wb_o_valid(wb_o_valid), .wb_o_ready(wb_o_ready),
        .wb_o_rd(wb_o_rd), .wb_o_data(wb_o_data)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural multiplier ----------------
    function automatic logic [63:0] prod(input logic [31:0] a, input logic [31:0] b,
                                         input logic sa, input logic sb_);
        logic signed [64:0] ea, eb, p;
        ea = sa  ? {{33{a[31]}}, a} : {33'b0, a};
        eb = sb_ ? {{33{b[31]}}, b} : {33'b0, b};
        p  = ea * eb;
        return p[63:0];
    endfunction

    logic        m_busy;
    logic        m_ov;
    int          m_cnt;
    int          m_lat = 2;
    int          m_reqs;
    logic [63:0] m_res;

    assign mul_i_ready = !m_busy;
    assign mul_o_valid = m_ov;
    assign mul_o_resh  = m_res[63:32];
    assign mul_o_resl  = m_res[31:0];

    always @(posedge clock) begin
        if (!reset) begin
            m_busy <= 1'b0;
            m_ov   <= 1'b0;
            m_cnt  <= 0;
            m_res  <= '0;
            m_reqs <= 0;
        end else begin
            if (mul_i_valid && mul_i_ready) begin
                m_busy <= 1'b1;
                m_cnt  <= m_lat;
                m_res  <= prod(mul_i_multiplicand, mul_i_multiplier,
                               mul_i_signed1, mul_i_signed2);
                m_reqs <= m_reqs + 1;
            end else if (m_busy && !m_ov) begin
                if (m_cnt == 0) m_ov <= 1'b1;
                else            m_cnt <= m_cnt - 1;
            end
            if (m_ov && mul_o_ready) begin
                m_ov   <= 1'b0;
                m_busy <= 1'b0;
            end
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (reset) begin
                chk("mutex_req_rsp", {63'b0, mul_i_valid & mul_o_ready}, 64'd0);
                if (wb_o_valid && wb_o_ready) begin
                    if (sb.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_wb: got rd=%0d data=%0h expected none",
                                 wb_o_rd, wb_o_data);
                    end else begin
                        e = sb.pop_front();
                        chk("wb_rd", {59'b0, wb_o_rd}, {59'b0, e.rd});
                        chk("wb_data", {32'b0, wb_o_data}, {32'b0, e.data});
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_outputs_reset();
        chk("rst_mul_i_valid", {63'b0, mul_i_valid}, 64'd0);
        chk("rst_mul_o_ready", {63'b0, mul_o_ready}, 64'd0);
        chk("rst_wb_o_valid", {63'b0, wb_o_valid}, 64'd0);
        chk("rst_wb_o_data", {32'b0, wb_o_data}, 64'd0);
        chk("rst_wb_o_rd", {59'b0, wb_o_rd}, 64'd0);
        chk("rst_multiplicand", {32'b0, mul_i_multiplicand}, 64'd0);
        chk("rst_multiplier", {32'b0, mul_i_multiplier}, 64'd0);
        chk("rst_signed", {62'b0, mul_i_signed1, mul_i_signed2}, 64'd0);
        chk("rst_op_i_ready", {63'b0, op_i_ready}, 64'd1);
    endtask

    // Present an op and hold it until accepted; optionally expect a writeback.
    task automatic issue(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic push, input logic [31:0] data);
        int t;
        exp_t e;
        op_i_func  = f;
        op_i_rs1   = a;
        op_i_rs2   = b;
        op_i_rd    = rd;
        op_i_valid = 1'b1;
        t = 0;
        @(negedge clock);
        while (!op_i_ready && t < 50) begin
            @(negedge clock);
            t++;
        end
        if (t >= 50) chk("accept_timeout", 64'd0, 64'd1);
        if (push) begin
            e.rd   = rd;
            e.data = data;
            sb.push_back(e);
        end
        tick();
        op_i_valid = 1'b0;
    endtask

    task automatic run_op(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] data,
                          input logic hit, input logic s1, input logic s2);
        int t;
        int base;
        base = m_reqs;
        issue(f, a, b, rd, 1'b1, data);
        @(negedge clock);
        chk("hit_latency_wb_valid", {63'b0, wb_o_valid}, {63'b0, hit});
        chk("req_latency_mul_valid", {63'b0, mul_i_valid}, {63'b0, !hit});
        if (!hit) begin
            chk("mul_signed", {62'b0, mul_i_signed1, mul_i_signed2}, {62'b0, s1, s2});
            chk("mul_operands", {mul_i_multiplicand, mul_i_multiplier}, {a, b});
        end
        t = 0;
        while (sb.size() != 0 && t < 100) begin
            @(negedge clock);
            t++;
        end
        if (t >= 100) chk("wb_timeout", 64'd0, 64'd1);
        tick();
        chk("mul_pass_count", 64'(m_reqs - base), {63'b0, !hit});
    endtask

    task automatic wait_sig(input string nm, ref logic s, input logic lvl);
        int t;
        t = 0;
        @(negedge clock);
        while (s !== lvl && t < 100) begin
            @(negedge clock);
            t++;
        end
        if (t >= 100) chk(nm, 64'd0, 64'd1);
    endtask

    typedef struct {
        logic [1:0]  func;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        hit;
        logic        s1;
        logic        s2;
    } vec_t;

    vec_t vt[12];

    initial begin
        vt[0]  = '{2'b01, 32'hFFFFFFFE, 32'h00000003, 5'd1,  32'hFFFFFFFF, 1'b0, 1'b1, 1'b1};
        vt[1]  = '{2'b00, 32'hFFFFFFFE, 32'h00000003, 5'd2,  32'hFFFFFFFA, 1'b1, 1'b1, 1'b0};
        vt[2]  = '{2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3,  32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
        vt[3]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4,  32'h00000000, 1'b0, 1'b1, 1'b1};
        vt[4]  = '{2'b10, 32'hFFFFFFFF, 32'h00000002, 5'd5,  32'hFFFFFFFF, 1'b0, 1'b1, 1'b0};
        vt[5]  = '{2'b00, 32'hFFFFFFFF, 32'h00000002, 5'd6,  32'hFFFFFFFE, 1'b1, 1'b1, 1'b0};
        vt[6]  = '{2'b11, 32'hFFFFFFFF, 32'h00000002, 5'd7,  32'h00000001, 1'b0, 1'b0, 1'b0};
        vt[7]  = '{2'b00, 32'h00010000, 32'h00010000, 5'd8,  32'h00000000, 1'b0, 1'b1, 1'b0};
        vt[8]  = '{2'b11, 32'h00010000, 32'h00010000, 5'd9,  32'h00000001, 1'b0, 1'b0, 1'b0};
        vt[9]  = '{2'b01, 32'h00010000, 32'h00010000, 5'd10, 32'h00000001, 1'b0, 1'b1, 1'b1};
        vt[10] = '{2'b10, 32'h80000000, 32'h80000000, 5'd11, 32'hC0000000, 1'b0, 1'b1, 1'b0};
        vt[11] = '{2'b00, 32'h80000000, 32'h80000000, 5'd12, 32'h00000000, 1'b1, 1'b1, 1'b0};

        // Reset state
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        @(negedge clock);
        chk_outputs_reset();
        tick();

        // Table-driven ops with varying multiplier latency
        for (int i = 0; i < 12; i++) begin
            m_lat = i % 4;
            run_op(vt[i].func, vt[i].rs1, vt[i].rs2, vt[i].rd, vt[i].data,
                   vt[i].hit, vt[i].s1, vt[i].s2);
        end

        // Writeback backpressure: 5 cycles held
        m_lat = 1;
        wb_o_ready = 1'b0;
        issue(2'b00, 32'd3, 32'd5, 5'd7, 1'b1, 32'd15);
        wait_sig("wb_valid_timeout", wb_o_valid, 1'b1);
        for (int k = 0; k < 5; k++) begin
            chk("bp_wb_valid", {63'b0, wb_o_valid}, 64'd1);
            chk("bp_wb_data", {32'b0, wb_o_data}, 64'd15);
            chk("bp_wb_rd", {59'b0, wb_o_rd}, 64'd7);
            chk("bp_op_ready", {63'b0, op_i_ready}, 64'd0);
            @(negedge clock);
        end
        tick();
        wb_o_ready = 1'b1;
        tick();
        @(negedge clock);
        chk("bp_release_wb_valid", {63'b0, wb_o_valid}, 64'd0);
        chk("bp_release_idle", {63'b0, op_i_ready}, 64'd1);
        chk("bp_sb_empty", 64'(sb.size()), 64'd0);
        tick();

        // Flush two cycles into WAIT: drain, no writeback, cache untouched
        m_lat = 10;
        issue(2'b11, 32'd7, 32'd9, 5'd3, 1'b0, 32'd0);
        wait_sig("wait_timeout", mul_o_ready, 1'b1);
        tick();
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        @(negedge clock);
        chk("drain_mul_o_ready", {63'b0, mul_o_ready}, 64'd1);
        chk("drain_op_ready", {63'b0, op_i_ready}, 64'd0);
        wait_sig("drain_timeout", mul_o_ready, 1'b0);
        chk("drain_no_wb", {63'b0, wb_o_valid}, 64'd0);
        chk("drain_mul_idle", {63'b0, m_busy}, 64'd0);
        tick();
        m_lat = 2;
        run_op(2'b00, 32'd7, 32'd9, 5'd4, 32'd63, 1'b0, 1'b1, 1'b0);

        // Reset while in WAIT; cache cleared afterwards
        run_op(2'b11, 32'd5, 32'd6, 5'd1, 32'd0, 1'b0, 1'b0, 1'b0);
        m_lat = 6;
        issue(2'b00, 32'd100, 32'd200, 5'd2, 1'b0, 32'd0);
        wait_sig("wait2_timeout", mul_o_ready, 1'b1);
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        @(negedge clock);
        chk_outputs_reset();
        tick();
        m_lat = 1;
        run_op(2'b11, 32'd5, 32'd6, 5'd1, 32'd0, 1'b0, 1'b0, 1'b0);

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
